cpu_cache_ctrl: RTL and testbench
=================================

# cpu_cache_ctrl

Controller FSM that drives `cpu_cache` on behalf of the CPU load/store unit. It accepts one word-sized read or write per request, probes the cache, and serves hits directly. On a miss it writes back a dirty victim line to the memory controller, fetches the new 512-bit line, installs it, and replays the access. Policy is direct-mapped, write-back and write-allocate; the block sits between the CPU pipeline and `mem_ctrl`.

## Interface
- `ADDR_W`, default 32: CPU byte-address width. Must satisfy `ADDR_W = TAG_W + IDX_W + OFF_W`.
- `TAG_W`, default 18: tag width, taken from address bits [31:14].
- `IDX_W`, default 8: line index width, taken from address bits [13:6].
- `OFF_W`, default 6: byte offset within a line, taken from address bits [5:0].
- `LINE_W`, default 512: cache line width in bits.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `cpu_req`, in, 1: request strobe. Sampled only in IDLE.
- `cpu_wr`, in, 1: 1 = store, 0 = load.
- `cpu_addr`, in, ADDR_W: byte address. Bits [1:0] are ignored.
- `cpu_wdata`, in, 32: store data.
- `cpu_busy`, out, 1: high whenever the state is not IDLE.
- `cpu_done`, out, 1: one-cycle completion pulse.
- `cpu_rdata`, out, 32: load data. Valid while `cpu_done` is high and held until the next `cpu_done`.
- `c_en`, `c_comp`, `c_wr`, `c_valid_in`, `c_replace_line`, out, 1 each: cache control signals.
- `c_index`, out, IDX_W: cache line index.
- `c_offset`, out, OFF_W: cache byte offset. Bits [1:0] are always 0.
- `c_tag_in`, out, TAG_W: tag presented to the cache.
- `c_data_in`, out, 32: word write data to the cache.
- `c_cl_in`, out, LINE_W: full line presented to the cache on install.
- `c_hit`, `c_dirty`, `c_valid`, in, 1 each: cache status.
- `c_tag_out`, in, TAG_W: stored tag of the indexed line.
- `c_data_out`, in, 32: word read from the cache.
- `c_cl_out`, in, LINE_W: full line read from the cache. Cache reads are combinational; cache writes commit at the clock edge.
- `mem_rd_req`, out, 1: line-fetch request to the memory controller.
- `mem_wr_req`, out, 1: line-writeback request to the memory controller.
- `mem_addr`, out, ADDR_W: line address, always 64-byte aligned.
- `mem_wr_data`, out, LINE_W: writeback line data.
- `mem_rd_valid`, in, 1: fetched line is valid on `mem_rd_data`.
- `mem_rd_data`, in, LINE_W: fetched line data.
- `mem_wr_done`, in, 1: writeback accepted by the memory controller.

## Operation
- IDLE → COMPARE when `cpu_req` is high. Latch `cpu_wr`, `cpu_addr` and `cpu_wdata` into request registers. Requests arriving while busy are ignored (not queued).
- COMPARE: drive `c_en=1`, `c_comp=1`, `c_wr=0`, with index, offset and tag taken from the latched address. Hit is defined as `c_hit & c_valid`.
  - Load hit: capture `c_data_out` into `cpu_rdata`, go to DONE.
  - Store hit: go to WRITE.
  - Miss with `c_valid & c_dirty`: latch `c_cl_out` and victim address `{c_tag_out, index, 6'b0}`, go to WB.
  - Miss otherwise: go to FILL.
- WRITE: drive `c_en=1`, `c_comp=1`, `c_wr=1`, `c_data_in` = latched wdata. The cache sets the dirty bit. Go to DONE.
- WB: hold `mem_wr_req=1`, with `mem_addr` = victim address and `mem_wr_data` = latched line, until `mem_wr_done` is seen. Then go to FILL.
- FILL: hold `mem_rd_req=1`, with `mem_addr = {tag, index, 6'b0}`, until `mem_rd_valid` is seen. Latch `mem_rd_data`, then go to INSTALL.
- INSTALL: one cycle with `c_en=1`, `c_wr=1`, `c_comp=0`, `c_replace_line=1`, `c_valid_in=1`, `c_tag_in` = tag, `c_cl_in` = latched line. This leaves the line valid and clean. Go to COMPARE; the replay hits.
- DONE: `cpu_done=1` for one cycle, then go to IDLE.
- `mem_rd_req` and `mem_wr_req` are never high together. Each stays level until its own completion signal is seen.
- Reset (any state): go to IDLE. All outputs 0, including `cpu_rdata` and the latched registers. An outstanding memory request is dropped and `mem_ctrl` must tolerate the drop. Cache array contents are not touched by this block.

## Timing
- Load hit: `cpu_req` sampled at edge 0; COMPARE in cycle 1; `cpu_done` in cycle 2.
- Store hit: COMPARE in cycle 1, WRITE in cycle 2, `cpu_done` in cycle 3.
- Clean miss: COMPARE, FILL (N cycles until `mem_rd_valid`), INSTALL, COMPARE, then either DONE, or WRITE then DONE.
- Dirty miss: same as a clean miss, with WB inserted before FILL.
- `mem_rd_valid` or `mem_wr_done` arriving in the same cycle the request is first raised is legal and completes the state.
- A new request may be sampled in the cycle after `cpu_done`. There is no zero-bubble back-to-back.

## Structure
- Shared package `cpu_cache_pkg` holds:
  - the state enum: IDLE, COMPARE, WRITE, WB, FILL, INSTALL, DONE;
  - the widths TAG_W, IDX_W, OFF_W and LINE_W;
  - address-field extraction helpers.
- Single module; no sub-module is warranted. A bench-only behavioural `cpu_cache` plus a memory-controller model with programmable latency are used for verification.

## Test plan
1. Cold load at 0x0000_4044, with memory word 0x4044 = 0xDEADBEEF and fill latency 5:
   - one FILL request at `mem_addr` 0x0000_4040;
   - INSTALL, then replay hit;
   - `cpu_done` with `cpu_rdata` = 0xDEADBEEF;
   - `mem_wr_req` never asserted.
2. Store 0x12345678 to 0x0000_4048 (line already resident) → no memory traffic; `cpu_done` 3 cycles after the request; the cache line's dirty bit is set.
3. Load 0x0000_8048 after test 2 (same index 0x01, new tag):
   - WB at `mem_addr` 0x0000_4040 whose data contains 0x12345678 in word 2;
   - then FILL at 0x0000_8040;
   - then `cpu_done`.
4. Store miss to a clean line → FILL, INSTALL, COMPARE, WRITE, DONE; the line ends valid and dirty with the new word.
5. Assert `rst` during FILL → next cycle IDLE, `mem_rd_req=0`, `cpu_busy=0`. A later `mem_rd_valid` pulse is ignored.
6. `cpu_req` held high for 20 cycles with a changing address → each request is latched only in IDLE; exactly one `cpu_done` per accepted request.

Source files
------------

// File: rtl/cpu_cache_pkg.sv
// Shared types, widths and address-field helpers for the CPU cache controller.
package cpu_cache_pkg;

  localparam int ADDR_BITS = 32;
  localparam int TAG_BITS  = 18;
  localparam int IDX_BITS  = 8;
  localparam int OFF_BITS  = 6;
  localparam int LINE_BITS = 512;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPARE = 3'd1,
    S_WRITE   = 3'd2,
    S_WB      = 3'd3,
    S_FILL    = 3'd4,
    S_INSTALL = 3'd5,
    S_DONE    = 3'd6
  } cache_state_e;

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] addr);
    return addr[ADDR_BITS-1 -: TAG_BITS];
  endfunction

  function automatic logic [IDX_BITS-1:0] addr_idx(input logic [ADDR_BITS-1:0] addr);
    return addr[OFF_BITS +: IDX_BITS];
  endfunction

  // Word-aligned byte offset: the two byte-select bits are forced low.
  function automatic logic [OFF_BITS-1:0] addr_word_off(input logic [ADDR_BITS-1:0] addr);
    return {addr[OFF_BITS-1:2], 2'b00};
  endfunction

  function automatic logic [ADDR_BITS-1:0] line_addr(input logic [TAG_BITS-1:0] tag,
                                                     input logic [IDX_BITS-1:0] idx);
    return {tag, idx, {OFF_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cpu_cache_ctrl.sv
// Direct-mapped write-back / write-allocate cache controller: probes the cache
// for one CPU word access, writes back a dirty victim, fills, installs and replays.
module cpu_cache_ctrl
  import cpu_cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_BITS,
  parameter int TAG_W  = TAG_BITS,
  parameter int IDX_W  = IDX_BITS,
  parameter int OFF_W  = OFF_BITS,
  parameter int LINE_W = LINE_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              c_en,
  output logic              c_comp,
  output logic              c_wr,
  output logic              c_valid_in,
  output logic              c_replace_line,
  output logic [IDX_W-1:0]  c_index,
  output logic [OFF_W-1:0]  c_offset,
  output logic [TAG_W-1:0]  c_tag_in,
  output logic [31:0]       c_data_in,
  output logic [LINE_W-1:0] c_cl_in,
  input  logic              c_hit,
  input  logic              c_dirty,
  input  logic              c_valid,
  input  logic [TAG_W-1:0]  c_tag_out,
  input  logic [31:0]       c_data_out,
  input  logic [LINE_W-1:0] c_cl_out,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wr_data,
  input  logic              mem_rd_valid,
  input  logic [LINE_W-1:0] mem_rd_data,
  input  logic              mem_wr_done
);

  cache_state_e      state_r;
  cache_state_e      next_state_s;
  logic              req_wr_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic [31:0]       req_wdata_r;
  logic [LINE_W-1:0] line_r;
  logic              hit_s;
  logic              dirty_miss_s;
  logic [ADDR_W-1:0] victim_s;
  logic [ADDR_W-1:0] fill_addr_s;
  logic [ADDR_W-1:0] mem_addr_next_s;

  // Cache address fields and data all come from the latched request or line.
  assign c_index     = addr_idx(req_addr_r);
  assign c_offset    = addr_word_off(req_addr_r);
  assign c_tag_in    = addr_tag(req_addr_r);
  assign c_data_in   = req_wdata_r;
  assign c_cl_in     = line_r;
  assign mem_wr_data = line_r;

  // Next-state selection and the memory address to present in that state.
  always_comb begin
    next_state_s    = state_r;
    hit_s           = c_hit & c_valid;
    dirty_miss_s    = ~hit_s & c_valid & c_dirty;
    victim_s        = line_addr(c_tag_out, addr_idx(req_addr_r));
    fill_addr_s     = line_addr(addr_tag(req_addr_r), addr_idx(req_addr_r));
    mem_addr_next_s = {ADDR_W{1'b0}};

    case (state_r)
      S_IDLE: begin
        if (cpu_req) next_state_s = S_COMPARE;
        else         next_state_s = S_IDLE;
      end
      S_COMPARE: begin
        if (hit_s) begin
          if (req_wr_r) next_state_s = S_WRITE;
          else          next_state_s = S_DONE;
        end else if (dirty_miss_s) begin
          next_state_s = S_WB;
        end else begin
          next_state_s = S_FILL;
        end
      end
      S_WRITE:   next_state_s = S_DONE;
      S_WB: begin
        if (mem_wr_done) next_state_s = S_FILL;
        else             next_state_s = S_WB;
      end
      S_FILL: begin
        if (mem_rd_valid) next_state_s = S_INSTALL;
        else              next_state_s = S_FILL;
      end
      S_INSTALL: next_state_s = S_COMPARE;
      S_DONE:    next_state_s = S_IDLE;
      default:   next_state_s = S_IDLE;
    endcase

    // The victim address is only visible in COMPARE; WB keeps what it captured.
    if (next_state_s == S_WB) begin
      if (state_r == S_WB) mem_addr_next_s = mem_addr;
      else                 mem_addr_next_s = victim_s;
    end else if (next_state_s == S_FILL) begin
      mem_addr_next_s = fill_addr_s;
    end else begin
      mem_addr_next_s = {ADDR_W{1'b0}};
    end
  end

  // State, request/line capture and all outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_IDLE;
      req_wr_r       <= 1'b0;
      req_addr_r     <= {ADDR_W{1'b0}};
      req_wdata_r    <= 32'h0000_0000;
      line_r         <= {LINE_W{1'b0}};
      cpu_busy       <= 1'b0;
      cpu_done       <= 1'b0;
      cpu_rdata      <= 32'h0000_0000;
      c_en           <= 1'b0;
      c_comp         <= 1'b0;
      c_wr           <= 1'b0;
      c_valid_in     <= 1'b0;
      c_replace_line <= 1'b0;
      mem_rd_req     <= 1'b0;
      mem_wr_req     <= 1'b0;
      mem_addr       <= {ADDR_W{1'b0}};
    end else begin
      state_r        <= next_state_s;
      cpu_busy       <= (next_state_s != S_IDLE);
      cpu_done       <= (next_state_s == S_DONE);
      c_en           <= (next_state_s == S_COMPARE) || (next_state_s == S_WRITE) ||
                        (next_state_s == S_INSTALL);
      c_comp         <= (next_state_s == S_COMPARE) || (next_state_s == S_WRITE);
      c_wr           <= (next_state_s == S_WRITE) || (next_state_s == S_INSTALL);
      c_valid_in     <= (next_state_s == S_INSTALL);
      c_replace_line <= (next_state_s == S_INSTALL);
      mem_wr_req     <= (next_state_s == S_WB);
      mem_rd_req     <= (next_state_s == S_FILL);
      mem_addr       <= mem_addr_next_s;

      if ((state_r == S_IDLE) && cpu_req) begin
        req_wr_r    <= cpu_wr;
        req_addr_r  <= cpu_addr;
        req_wdata_r <= cpu_wdata;
      end
      if ((state_r == S_COMPARE) && hit_s && !req_wr_r) begin
        cpu_rdata <= c_data_out;
      end
      // One line buffer serves both the victim being written back and the fill.
      if ((state_r == S_COMPARE) && dirty_miss_s) begin
        line_r <= c_cl_out;
      end else if ((state_r == S_FILL) && mem_rd_valid) begin
        line_r <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_cpu_cache_ctrl.sv
// Scoreboard bench for cpu_cache_ctrl with a behavioural cache, a latency-programmable
// memory controller and an abstract reference model of the memory/cache policy.
module tb_cpu_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_wr;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic         cpu_busy, cpu_done;
  logic [31:0]  cpu_rdata;
  logic         c_en, c_comp, c_wr, c_valid_in, c_replace_line;
  logic [7:0]   c_index;
  logic [5:0]   c_offset;
  logic [17:0]  c_tag_in;
  logic [31:0]  c_data_in;
  logic [511:0] c_cl_in;
  logic         c_hit, c_dirty, c_valid;
  logic [17:0]  c_tag_out;
  logic [31:0]  c_data_out;
  logic [511:0] c_cl_out;
  logic         mem_rd_req, mem_wr_req;
  logic [31:0]  mem_addr;
  logic [511:0] mem_wr_data;
  logic         mem_rd_valid;
  logic [511:0] mem_rd_data;
  logic         mem_wr_done;

  always #5 clk = ~clk;

  cpu_cache_ctrl #(.ADDR_W(32), .TAG_W(18), .IDX_W(8), .OFF_W(6), .LINE_W(512)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .c_en(c_en), .c_comp(c_comp), .c_wr(c_wr), .c_valid_in(c_valid_in),
    .c_replace_line(c_replace_line), .c_index(c_index), .c_offset(c_offset),
    .c_tag_in(c_tag_in), .c_data_in(c_data_in), .c_cl_in(c_cl_in),
    .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
    .c_data_out(c_data_out), .c_cl_out(c_cl_out),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_wr_done(mem_wr_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] gen_word(input bit [29:0] wa);
    return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- behavioural cache ----------------
  logic         cv [256];
  logic         cd [256];
  logic [17:0]  ct [256];
  logic [511:0] cl [256];

  assign c_valid    = cv[c_index];
  assign c_dirty    = cd[c_index];
  assign c_tag_out  = ct[c_index];
  assign c_cl_out   = cl[c_index];
  assign c_data_out = cl[c_index][{c_offset[5:2], 5'b00000} +: 32];
  assign c_hit      = c_en & c_comp & cv[c_index] & (ct[c_index] == c_tag_in);

  always @(posedge clk) begin
    if (c_en && c_wr) begin
      if (c_comp) begin
        if (cv[c_index] && ct[c_index] == c_tag_in) begin
          cl[c_index][{c_offset[5:2], 5'b00000} +: 32] <= c_data_in;
          cd[c_index] <= 1'b1;
        end
      end else if (c_replace_line) begin
        cl[c_index] <= c_cl_in;
        ct[c_index] <= c_tag_in;
        cv[c_index] <= c_valid_in;
        cd[c_index] <= 1'b0;
      end
    end
  end

  // ---------------- memory controller model ----------------
  logic [31:0] bmem [bit [29:0]];
  int unsigned rd_lat = 5, wr_lat = 3, rd_cnt = 0, wr_cnt = 0;
  logic force_rd_valid = 1'b0;

  function automatic logic [31:0] bmem_rd(input bit [29:0] wa);
    if (bmem.exists(wa)) return bmem[wa];
    else return gen_word(wa);
  endfunction

  assign mem_rd_valid = (mem_rd_req && rd_cnt == rd_lat) || force_rd_valid;
  assign mem_wr_done  = mem_wr_req && wr_cnt == wr_lat;

  always @(posedge clk) begin
    if (mem_rd_req && !mem_rd_valid) rd_cnt <= rd_cnt + 1; else rd_cnt <= 0;
    if (mem_wr_req && !mem_wr_done)  wr_cnt <= wr_cnt + 1; else wr_cnt <= 0;
  end

  always @(negedge clk) begin
    if (mem_wr_req && mem_wr_done)
      for (int w = 0; w < 16; w++) bmem[{mem_addr[31:6], w[3:0]}] = mem_wr_data[w*32 +: 32];
    for (int w = 0; w < 16; w++) mem_rd_data[w*32 +: 32] = bmem_rd({mem_addr[31:6], w[3:0]});
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit           wr;
    logic [31:0]  rdata;
    int unsigned  done_cyc;
    bit           wb;
    logic [31:0]  wb_addr;
    logic [511:0] wb_line;
    bit           fill;
    logic [31:0]  fill_addr;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] ref_mem [bit [29:0]];
  logic [17:0] rtag [256];
  bit          rvalid [256];
  bit          rdirty [256];
  int unsigned next_free = 0;

  function automatic logic [31:0] ref_rd(input bit [29:0] wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    else return gen_word(wa);
  endfunction

  task automatic predict_push(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          idx = int'(addr[13:6]);
    logic [17:0] tag = addr[31:14];
    bit          hit = rvalid[idx] && (rtag[idx] == tag);
    int unsigned lat;
    e.wr        = wr;
    e.rdata     = 32'h0;
    e.wb        = !hit && rvalid[idx] && rdirty[idx];
    e.wb_addr   = (rtag[idx] << 14) | (idx << 6);
    for (int w = 0; w < 16; w++) e.wb_line[w*32 +: 32] = ref_rd({e.wb_addr[31:6], w[3:0]});
    e.fill      = !hit;
    e.fill_addr = addr & 32'hFFFF_FFC0;
    // Cycles from COMPARE through DONE inclusive.
    if (hit) lat = wr ? 3 : 2;
    else     lat = rd_lat + 5 + (wr ? 1 : 0) + (e.wb ? wr_lat + 1 : 0);
    e.done_cyc  = cyc + lat;
    next_free   = cyc + lat + 1;
    rtag[idx]   = tag;
    rvalid[idx] = 1'b1;
    rdirty[idx] = hit ? (rdirty[idx] | wr) : wr;
    if (wr) ref_mem[addr[31:2]] = wdata;
    else    e.rdata = ref_rd(addr[31:2]);
    sb_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int           obs_wb, obs_fill, obs_wrreq;
  logic [31:0]  obs_wb_addr, obs_fill_addr, last_wb_addr;
  logic [511:0] obs_wb_line, last_wb_line;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (rst) begin
      obs_wb = 0; obs_fill = 0; obs_wrreq = 0;
    end else begin
      if (mem_rd_req && mem_wr_req) begin
        n_tests++; n_fail++;
        $display("FAIL mem_req_overlap: rd_req=1 wr_req=1 required at most one (cycle %0d)", cyc);
      end
      if (mem_wr_req) obs_wrreq++;
      if (mem_wr_req && mem_wr_done) begin
        obs_wb++; obs_wb_addr = mem_addr; obs_wb_line = mem_wr_data;
        last_wb_addr = mem_addr; last_wb_line = mem_wr_data;
      end
      if (mem_rd_req && mem_rd_valid) begin
        obs_fill++; obs_fill_addr = mem_addr;
      end
      if (cpu_done) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: cpu_done with no outstanding request (cycle %0d)", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("done_cycle", 512'(cyc), 512'(mon_e.done_cyc));
          if (!mon_e.wr) chk("load_rdata", 512'(cpu_rdata), 512'(mon_e.rdata));
          chk("wb_count", 512'(obs_wb), 512'(mon_e.wb));
          if (mon_e.wb) begin
            chk("wb_addr", 512'(obs_wb_addr), 512'(mon_e.wb_addr));
            chk("wb_line", obs_wb_line, mon_e.wb_line);
          end else begin
            chk("wr_req_quiet", 512'(obs_wrreq), 512'(0));
          end
          chk("fill_count", 512'(obs_fill), 512'(mon_e.fill));
          if (mon_e.fill) chk("fill_addr", 512'(obs_fill_addr), 512'(mon_e.fill_addr));
        end
        obs_wb = 0; obs_fill = 0; obs_wrreq = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_cycle(input bit req, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata);
    @(negedge clk);
    cpu_req = req; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    if (req && cyc >= next_free) predict_push(wr, addr, wdata);
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    drive_cycle(1'b1, wr, addr, wdata);
    while (cyc < next_free) drive_cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr(input int idx_base);
    int unsigned t = $urandom_range(0, 3);
    int unsigned i = $urandom_range(0, 3);
    int unsigned w = $urandom_range(0, 15);
    return (t << 14) | ((idx_base + i) << 6) | (w << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      cv[i] = 1'b0; cd[i] = 1'b0; ct[i] = 18'h0; cl[i] = 512'h0;
      rvalid[i] = 1'b0; rdirty[i] = 1'b0; rtag[i] = 18'h0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 512'(cpu_busy), 512'(0));
    chk("rst_done", 512'(cpu_done), 512'(0));
    chk("rst_rdata", 512'(cpu_rdata), 512'(0));
    chk("rst_rd_req", 512'(mem_rd_req), 512'(0));
    chk("rst_wr_req", 512'(mem_wr_req), 512'(0));
    chk("rst_c_en", 512'(c_en), 512'(0));
    chk("rst_mem_addr", 512'(mem_addr), 512'(0));
    rst = 1'b0;
    next_free = cyc + 1;

    // Cold load, fill latency 5.
    bmem[30'h1011] = 32'hDEAD_BEEF;
    ref_mem[30'h1011] = 32'hDEAD_BEEF;
    rd_lat = 5; wr_lat = 3;
    issue(1'b0, 32'h0000_4044, 32'h0);
    chk("t1_rdata", 512'(cpu_rdata), 512'(32'hDEAD_BEEF));

    // Store hit on the resident line.
    issue(1'b1, 32'h0000_4048, 32'h1234_5678);
    chk("t2_dirty", 512'(cd[1]), 512'(1));

    // Conflict load forces writeback of the dirty line.
    issue(1'b0, 32'h0000_8048, 32'h0);
    chk("t3_wb_addr", 512'(last_wb_addr), 512'(32'h0000_4040));
    chk("t3_wb_word2", 512'(last_wb_line[95:64]), 512'(32'h1234_5678));

    // Store miss over a clean line.
    issue(1'b0, 32'h0001_0100, 32'h0);
    issue(1'b1, 32'h0002_0104, 32'hCAFE_F00D);
    chk("t4_valid", 512'(cv[4]), 512'(1));
    chk("t4_dirty", 512'(cd[4]), 512'(1));
    chk("t4_tag", 512'(ct[4]), 512'(18'h8));
    chk("t4_word", 512'(cl[4][63:32]), 512'(32'hCAFE_F00D));

    // Reset in the middle of a fill.
    rd_lat = 10;
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0004_2000;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_fill_active", 512'(mem_rd_req), 512'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 512'(cpu_busy), 512'(0));
    chk("t5_rd_req", 512'(mem_rd_req), 512'(0));
    chk("t5_rdata", 512'(cpu_rdata), 512'(0));
    force_rd_valid = 1'b1;
    @(negedge clk);
    force_rd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_idle_after_pulse", 512'(cpu_busy), 512'(0));
    chk("t5_line_untouched", 512'(cv[128]), 512'(0));
    next_free = cyc;

    // Request held high for 20 cycles with a changing address.
    rd_lat = 2; wr_lat = 1;
    for (int k = 0; k < 20; k++)
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), rand_addr(16), $urandom);
    while (cyc < next_free) drive_cycle(1'b0, 1'b0, 32'h0, 32'h0);

    // Randomized traffic with varying memory latencies, including zero.
    for (int k = 0; k < 200; k++) begin
      rd_lat = $urandom_range(0, 4);
      wr_lat = $urandom_range(0, 4);
      issue(1'($urandom_range(0, 1)), rand_addr(8), $urandom);
    end

    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clk);
    chk("sb_drained", 512'(sb_q.size()), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
